// File: rtl/match_stim_pkg.sv
// Shared types, LFSR constants and helpers for the match stimulus generator.
package match_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned LFSR_W = 6;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 6'h01;
    // x^6 + x^5 + 1, Fibonacci form: feedback is the XOR of the masked bits
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 6'b110000;

    // Tap masks for other word widths; falls back to x^w + x^(w-1) + 1
    function automatic logic [31:0] taps_for(input int unsigned w);
        logic [31:0] t;
        case (w)
            4:       t = 32'h0000_000C;
            6:       t = 32'(LFSR_TAPS);
            8:       t = 32'h0000_00B8;
            16:      t = 32'h0000_B400;
            default: t = 32'h0000_0003 << (w - 2);
        endcase
        return t;
    endfunction

    // Increment that sticks at the all-ones value of a w-bit counter
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max;
        max = (w >= 32) ? 32'hFFFF_FFFF : ((32'(1) << w) - 32'(1));
        return (v >= max) ? max : v + 32'(1);
    endfunction

endpackage

// File: rtl/match_stim_gen_if.sv
// Stimulus/response bundle between the generator, its controller and the detector.
interface match_stim_gen_if #(
    parameter int unsigned W     = 3,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [2*W-1:0]   pattern;
    logic [CNT_W-1:0] num_words;
    logic             q;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             valid;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] match_count;

    modport master (
        input  start, pattern, num_words, q,
        output a, b, valid, done, pass, err_count, match_count
    );

    modport slave (
        output start, pattern, num_words, q,
        input  a, b, valid, done, pass, err_count, match_count
    );
endinterface

// File: rtl/match_stim_gen_lfsr_gen.sv
// Free-running Fibonacci LFSR that steps only when enabled.
module lfsr_gen #(
    parameter int unsigned       WIDTH = 6,
    parameter logic [WIDTH-1:0]  TAPS  = 6'b110000,
    parameter logic [WIDTH-1:0]  SEED  = 6'h01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (en) begin
            value <= {value[WIDTH-2:0], ^(value & TAPS)};
        end
    end

endmodule

// File: rtl/match_stim_gen.sv
// Emits LFSR words with a periodically injected pattern, predicts the detector
// response one cycle later and accumulates mismatch/match counts.
module match_stim_gen
    import match_stim_pkg::*;
#(
    parameter int unsigned W             = 3,
    parameter int unsigned INJECT_PERIOD = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    match_stim_gen_if.master  bus
);

    localparam int unsigned WW   = 2 * W;
    localparam int unsigned PH_W = (INJECT_PERIOD > 1) ? $clog2(INJECT_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(INJECT_PERIOD - 1);
    localparam logic [WW-1:0]   SEED      = WW'(LFSR_SEED);
    localparam logic [WW-1:0]   TAPS      = WW'(taps_for(WW));
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] k, k_nxt;
    logic [PH_W-1:0]  ph, ph_nxt;
    logic [WW-1:0]    pat_r, pat_nxt;
    logic [CNT_W-1:0] num_r, num_nxt;
    logic [WW-1:0]    word_r, word_nxt;
    logic             valid_r, valid_nxt;
    logic             done_r, done_nxt;
    logic             pass_r, pass_nxt;
    logic [CNT_W-1:0] err_r, err_nxt, err_chk;
    logic [CNT_W-1:0] match_r, match_nxt, match_chk;
    logic             exp_q;
    logic             chk_v;
    logic             lfsr_en;
    logic [WW-1:0]    lfsr;

    function automatic logic [PH_W-1:0] ph_wrap(input logic [PH_W-1:0] p);
        return (p == PH_LAST) ? '0 : p + PH_W'(1);
    endfunction

    lfsr_gen #(
        .WIDTH (WW),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .value (lfsr)
    );

    // Response check for the word shown in the previous cycle
    always_comb begin
        err_chk   = err_r;
        match_chk = match_r;
        if (chk_v) begin
            if (bus.q != exp_q) begin
                err_chk = CNT_W'(sat_inc(32'(err_r), CNT_W));
            end
            if (exp_q) begin
                match_chk = CNT_W'(sat_inc(32'(match_r), CNT_W));
            end
        end
    end

    // k/ph index the next word to emit; word_r holds the one on a/b
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        ph_nxt    = ph;
        pat_nxt   = pat_r;
        num_nxt   = num_r;
        word_nxt  = word_r;
        valid_nxt = 1'b0;
        done_nxt  = done_r;
        pass_nxt  = pass_r;
        err_nxt   = err_chk;
        match_nxt = match_chk;
        lfsr_en   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    err_nxt   = '0;
                    match_nxt = '0;
                    if (bus.num_words != '0) begin
                        pat_nxt   = bus.pattern;
                        num_nxt   = bus.num_words;
                        done_nxt  = 1'b0;
                        pass_nxt  = 1'b0;
                        word_nxt  = (PH_W'(0) == PH_LAST) ? bus.pattern : lfsr;
                        valid_nxt = 1'b1;
                        lfsr_en   = 1'b1;
                        k_nxt     = CNT_ONE;
                        ph_nxt    = ph_wrap('0);
                        state_nxt = RUN;
                    end else begin
                        done_nxt  = 1'b1;
                        pass_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (k == num_r) begin
                    state_nxt = DRAIN;
                end else begin
                    word_nxt  = (ph == PH_LAST) ? pat_r : lfsr;
                    valid_nxt = 1'b1;
                    lfsr_en   = 1'b1;
                    k_nxt     = k + CNT_ONE;
                    ph_nxt    = ph_wrap(ph);
                end
            end
            DRAIN: begin
                done_nxt  = 1'b1;
                pass_nxt  = (err_chk == '0);
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            ph      <= '0;
            pat_r   <= '0;
            num_r   <= '0;
            word_r  <= '0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= '0;
            match_r <= '0;
            exp_q   <= 1'b0;
            chk_v   <= 1'b0;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            ph      <= ph_nxt;
            pat_r   <= pat_nxt;
            num_r   <= num_nxt;
            word_r  <= word_nxt;
            valid_r <= valid_nxt;
            done_r  <= done_nxt;
            pass_r  <= pass_nxt;
            err_r   <= err_nxt;
            match_r <= match_nxt;
            exp_q   <= (word_r == pat_r);
            chk_v   <= valid_r;
        end
    end

    assign bus.a           = word_r[WW-1:W];
    assign bus.b           = word_r[W-1:0];
    assign bus.valid       = valid_r;
    assign bus.done        = done_r;
    assign bus.pass        = pass_r;
    assign bus.err_count   = err_r;
    assign bus.match_count = match_r;

endmodule

// File: tb/tb_match_stim_gen.sv
// Bench for match_stim_gen driving a registered 011011 detector on a/b/q.
module tb_match_stim_gen;

    localparam logic [5:0] DET_PAT = 6'b011011;

    logic clk;
    logic rst_n;
    logic det_q;
    int   q_mode;        // 0: detector, 1: tied low, 2: tied high
    int   checks;
    int   failures;
    logic [5:0] m_lfsr;  // model of the generator's pseudo-random source

    match_stim_gen_if #(.W(3), .CNT_W(8)) bus ();

    match_stim_gen #(
        .W             (3),
        .INJECT_PERIOD (4),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (!rst_n) det_q <= 1'b0;
        else        det_q <= ({bus.a, bus.b} == DET_PAT);
    end

    assign bus.q = (q_mode == 0) ? det_q : (q_mode == 2);

    // Polynomial x^6 + x^5 + 1: new low bit is bit5 xor bit4, word shifts up
    function automatic logic [5:0] lfsr_step(input logic [5:0] v);
        int x;
        x = int'(v);
        return 6'(((x * 2) % 64) + (((x / 32) + (x / 16)) % 2));
    endfunction

    // Full run: model predicts words and counters, then the DUT is walked cycle by cycle
    task automatic do_run(input string name, input int n, input logic [5:0] pat, input bit hold);
        logic [5:0] words[$];
        logic [5:0] w;
        int exp_err;
        int exp_match;
        bit e;
        bit qv;
        exp_err = 0;
        exp_match = 0;
        for (int k = 0; k < n; k++) begin
            w = ((k % 4) == 3) ? pat : m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            words.push_back(w);
            e  = (w == pat);
            qv = (q_mode == 0) ? (w == DET_PAT) : (q_mode == 2);
            if (qv != e) exp_err++;
            if (e) exp_match++;
        end
        if (exp_err > 255) exp_err = 255;
        if (exp_match > 255) exp_match = 255;

        bus.start = 1'b1;
        bus.pattern = pat;
        bus.num_words = 8'(n);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;

        if (n == 0) begin
            checks++;
            if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.valid !== 1'b0 ||
                bus.err_count !== 8'd0 || bus.match_count !== 8'd0) begin
                failures++;
                $display("FAIL %s zero_len: done=%b pass=%b valid=%b err=%0d match=%0d want 1 1 0 0 0",
                         name, bus.done, bus.pass, bus.valid, bus.err_count, bus.match_count);
            end
            return;
        end

        checks++;
        if (bus.done !== 1'b0 || bus.err_count !== 8'd0 || bus.match_count !== 8'd0) begin
            failures++;
            $display("FAIL %s cleared_at_start: done=%b err=%0d match=%0d want 0 0 0",
                     name, bus.done, bus.err_count, bus.match_count);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (bus.valid !== 1'b1 || {bus.a, bus.b} !== words[k]) begin
                failures++;
                $display("FAIL %s word%0d: valid=%b ab=%b want valid=1 ab=%b",
                         name, k, bus.valid, {bus.a, bus.b}, words[k]);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b0 || {bus.a, bus.b} !== words[n-1]) begin
            failures++;
            $display("FAIL %s drain: valid=%b done=%b ab=%b want 0 0 %b",
                     name, bus.valid, bus.done, {bus.a, bus.b}, words[n-1]);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.pass !== (exp_err == 0) ||
            bus.err_count !== 8'(exp_err) || bus.match_count !== 8'(exp_match) ||
            {bus.a, bus.b} !== words[n-1]) begin
            failures++;
            $display("FAIL %s result: done=%b valid=%b pass=%b err=%0d match=%0d ab=%b want 1 0 %b %0d %0d %b",
                     name, bus.done, bus.valid, bus.pass, bus.err_count, bus.match_count,
                     {bus.a, bus.b}, (exp_err == 0), exp_err, exp_match, words[n-1]);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0 ||
            bus.a !== 3'd0 || bus.b !== 3'd0 ||
            bus.err_count !== 8'd0 || bus.match_count !== 8'd0) begin
            failures++;
            $display("FAIL %s: valid=%b done=%b pass=%b a=%0d b=%0d err=%0d match=%0d want all 0",
                     name, bus.valid, bus.done, bus.pass, bus.a, bus.b, bus.err_count, bus.match_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.pattern = '0;
        bus.num_words = '0;
        q_mode = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        m_lfsr = 6'h01;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_zero_words();
        do_run("zero_words", 0, 6'h2A, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.valid !== 1'b0 || bus.done !== 1'b1 || bus.pass !== 1'b1) begin
                failures++;
                $display("FAIL zero_words_hold: valid=%b done=%b pass=%b want 0 1 1",
                         bus.valid, bus.done, bus.pass);
            end
        end
    endtask

    task automatic test_basic_match();
        q_mode = 0;
        do_run("basic_match", 4, DET_PAT, 1'b0);
    endtask

    task automatic test_q_low();
        q_mode = 1;
        do_run("q_tied_low", 8, $urandom_range(0, 63), 1'b0);
    endtask

    task automatic test_q_high();
        q_mode = 2;
        do_run("q_tied_high", 8, $urandom_range(0, 63), 1'b0);
    endtask

    task automatic test_reset_mid_run();
        logic [5:0] w;
        q_mode = 0;
        bus.start = 1'b1;
        bus.pattern = DET_PAT;
        bus.num_words = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            w = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            checks++;
            if (bus.valid !== 1'b1 || {bus.a, bus.b} !== w) begin
                failures++;
                $display("FAIL mid_reset_word%0d: valid=%b ab=%b want 1 %b", k, bus.valid, {bus.a, bus.b}, w);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_run_reset");
        rst_n = 1'b1;
        m_lfsr = 6'h01;
        @(negedge clk);
        check_reset_outputs("idle_after_mid_reset");
        do_run("restart_after_reset", 4, DET_PAT, 1'b0);
    endtask

    task automatic test_start_held();
        q_mode = 1;
        do_run("start_held", 8, DET_PAT, 1'b1);
        repeat (2) @(negedge clk);
        q_mode = 0;
        do_run("rerun_after_held", 4, DET_PAT, 1'b0);
    endtask

    task automatic test_random();
        int n;
        logic [5:0] pat;
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 24);
            pat = ($urandom_range(0, 1) == 1) ? DET_PAT : 6'($urandom_range(0, 63));
            q_mode = $urandom_range(0, 2);
            do_run($sformatf("random%0d", i), n, pat, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        q_mode = 0;
        do_run("b2b_first", 5, DET_PAT, 1'b0);
        do_run("b2b_second", 7, 6'($urandom_range(0, 63)), 1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_zero_words();
        test_basic_match();
        test_q_low();
        test_q_high();
        test_reset_mid_run();
        test_start_held();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
